// File: rtl/rtmc_pkg.sv
// rtmc_pkg: shared types and default sizes for the rtmc stepper sequencer
// Optional feature macro used by the sequencer files: RTMC_RAMP_EN (acceleration ramp).
package rtmc_pkg;
  localparam int RTMC_NUM_OUT   = 8;
  localparam int RTMC_PAT_DEPTH = 16;
  localparam int RTMC_DELAY_W   = 16;
  localparam int RTMC_POS_W     = 16;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_MOVE} seq_state_e;
endpackage

// File: rtl/rtmc_step_timer.sv
// rtmc_step_timer: step-period counter with optional acceleration ramp
// Ports: clk, rst_n (async active-low); i_active (state is RUN/MOVE); i_clear (entering IDLE);
//   i_step_delay (period minus one); i_ramp_start/i_ramp_dec (only with RTMC_RAMP_EN);
//   o_tick (counter reached eff_delay this cycle).
// Macro RTMC_RAMP_EN: eff_delay starts at max(ramp_start, step_delay) and drops by ramp_dec per step.
module rtmc_step_timer
  import rtmc_pkg::*;
#(
  parameter int DELAY_W = RTMC_DELAY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_active,
  input  logic               i_clear,
  input  logic [DELAY_W-1:0] i_step_delay,
`ifdef RTMC_RAMP_EN
  input  logic [DELAY_W-1:0] i_ramp_start,
  input  logic [DELAY_W-1:0] i_ramp_dec,
`endif
  output logic               o_tick
);
  logic [DELAY_W-1:0] r_cnt;
  logic [DELAY_W-1:0] w_eff;
`ifdef RTMC_RAMP_EN
  logic [DELAY_W-1:0] r_ramp;
  // r_ramp holds the ramp value alone; the live step_delay floor is applied here
  assign w_eff = (r_ramp > i_step_delay) ? r_ramp : i_step_delay;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ramp <= '0;
    else if (!i_active || i_clear) r_ramp <= i_ramp_start;
    else if (o_tick) r_ramp <= (r_ramp > i_ramp_dec) ? r_ramp - i_ramp_dec : '0;
`else
  assign w_eff = i_step_delay;
`endif
  // >= keeps the counter from running to wrap if step_delay shrinks below it mid-run
  assign o_tick = i_active && (r_cnt >= w_eff);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (!i_active || i_clear || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/rtmc_seq_engine.sv
// rtmc_seq_engine: parametrised stepper-pattern sequencer with position counter and move-to-target
// Ports: clk, rst_n (async active-low); i_pat_we/i_pat_addr/i_pat_wdata (table write);
//   i_step_delay, i_step_dir, i_step_size (rate/direction/stride); i_run (level), i_step,
//   i_move_start, i_abort, i_pos_clr (pulses); i_target (signed);
//   o_mc, o_mc_idx, o_position, o_busy, o_done.
// Macro RTMC_RAMP_EN adds i_ramp_start / i_ramp_dec for an acceleration ramp.
module rtmc_seq_engine
  import rtmc_pkg::*;
#(
  parameter  int NUM_OUT   = RTMC_NUM_OUT,
  parameter  int PAT_DEPTH = RTMC_PAT_DEPTH,
  parameter  int DELAY_W   = RTMC_DELAY_W,
  parameter  int POS_W     = RTMC_POS_W,
  localparam int IDX_W     = $clog2(PAT_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_pat_we,
  input  logic [IDX_W-1:0]   i_pat_addr,
  input  logic [NUM_OUT-1:0] i_pat_wdata,
  input  logic [DELAY_W-1:0] i_step_delay,
  input  logic               i_step_dir,
  input  logic [IDX_W-1:0]   i_step_size,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_move_start,
  input  logic               i_abort,
  input  logic [POS_W-1:0]   i_target,
  input  logic               i_pos_clr,
`ifdef RTMC_RAMP_EN
  input  logic [DELAY_W-1:0] i_ramp_start,
  input  logic [DELAY_W-1:0] i_ramp_dec,
`endif
  output logic [NUM_OUT-1:0] o_mc,
  output logic [IDX_W-1:0]   o_mc_idx,
  output logic [POS_W-1:0]   o_position,
  output logic               o_busy,
  output logic               o_done
);
  seq_state_e         r_state;
  logic               r_mv_dir;
  logic               r_busy;
  logic               r_done;
  logic [IDX_W-1:0]   r_idx;
  logic [POS_W-1:0]   r_pos;
  logic [NUM_OUT-1:0] r_mc;
  logic [NUM_OUT-1:0] r_pat [PAT_DEPTH];
  logic w_idle, w_move, w_tick, w_go_run, w_mv_req, w_mv_eq, w_go_move, w_single;
  logic w_fire, w_dir, w_land, w_to_idle;
  logic [IDX_W-1:0] w_size, w_idx_nxt;
  logic [POS_W-1:0] w_pos_nxt;
  assign w_idle    = (r_state == SEQ_IDLE);
  assign w_move    = (r_state == SEQ_MOVE);
  assign w_go_run  = w_idle && i_run && !i_abort;
  assign w_mv_req  = w_idle && !i_run && !i_abort && i_move_start;
  assign w_mv_eq   = w_mv_req && (i_target == r_pos);
  assign w_go_move = w_mv_req && !w_mv_eq;
  assign w_single  = w_idle && !i_run && !i_move_start && i_step;
  // a timed step is dropped on the cycle RUN/MOVE is being left
  assign w_fire    = w_single || (w_tick && !i_abort && (w_move || i_run));
  assign w_dir     = w_move ? r_mv_dir : i_step_dir;
  assign w_size    = (i_step_size == '0) ? IDX_W'(1) : i_step_size;
  assign w_idx_nxt = w_dir ? r_idx - w_size : r_idx + w_size;
  assign w_pos_nxt = i_pos_clr ? '0 : !w_fire ? r_pos : w_dir ? r_pos - POS_W'(1) : r_pos + POS_W'(1);
  assign w_land    = w_move && w_fire && (w_pos_nxt == i_target);
  assign w_to_idle = (r_state == SEQ_RUN && (!i_run || i_abort)) || (w_move && (i_abort || w_land));
  rtmc_step_timer #(.DELAY_W(DELAY_W)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_active    (!w_idle),
    .i_clear     (w_to_idle),
    .i_step_delay(i_step_delay),
`ifdef RTMC_RAMP_EN
    .i_ramp_start(i_ramp_start),
    .i_ramp_dec  (i_ramp_dec),
`endif
    .o_tick      (w_tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= SEQ_IDLE;
      r_mv_dir <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_idx    <= '0;
      r_pos    <= '0;
      r_mc     <= '0;
    end else begin
      r_state  <= w_to_idle ? SEQ_IDLE : w_go_run ? SEQ_RUN : w_go_move ? SEQ_MOVE : r_state;
      r_busy   <= w_to_idle ? 1'b0 : (w_go_run || w_go_move) ? 1'b1 : r_busy;
      r_mv_dir <= w_go_move ? ($signed(i_target) < $signed(r_pos)) : r_mv_dir;
      r_done   <= w_land || w_mv_eq;
      r_idx    <= w_fire ? w_idx_nxt : r_idx;
      r_pos    <= w_pos_nxt;
      r_mc     <= (i_pat_we && i_pat_addr == r_idx) ? i_pat_wdata : r_pat[r_idx];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < PAT_DEPTH; i++) r_pat[i] <= '0;
    end else if (i_pat_we) r_pat[i_pat_addr] <= i_pat_wdata;
  assign o_mc       = r_mc;
  assign o_mc_idx   = r_idx;
  assign o_position = r_pos;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
endmodule

// File: tb/tb_rtmc_seq_engine.sv
// tb_rtmc_seq_engine: self-checking bench for rtmc_seq_engine against a behavioural model
module tb_rtmc_seq_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pat_we;
  logic [3:0]  pat_addr;
  logic [7:0]  pat_wdata;
  logic [15:0] step_delay;
  logic        step_dir;
  logic [3:0]  step_size;
  logic        run, step, move_start, abort, pos_clr;
  logic [15:0] target;
  logic [15:0] ramp_start, ramp_dec;
  logic [7:0]  mc;
  logic [3:0]  mc_idx;
  logic [15:0] position;
  logic        busy, done;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_pat [16];
  int m_idx = 0;
  int m_pos = 0;
  always #5 clk = ~clk;
  rtmc_seq_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pat_we    (pat_we),
    .i_pat_addr  (pat_addr),
    .i_pat_wdata (pat_wdata),
    .i_step_delay(step_delay),
    .i_step_dir  (step_dir),
    .i_step_size (step_size),
    .i_run       (run),
    .i_step      (step),
    .i_move_start(move_start),
    .i_abort     (abort),
    .i_target    (target),
    .i_pos_clr   (pos_clr),
`ifdef RTMC_RAMP_EN
    .i_ramp_start(ramp_start),
    .i_ramp_dec  (ramp_dec),
`endif
    .o_mc        (mc),
    .o_mc_idx    (mc_idx),
    .o_position  (position),
    .o_busy      (busy),
    .o_done      (done)
  );
  function automatic logic [31:0] p16(input int v);
    return {16'h0, v[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_state(input string tag);
    chk({tag, "_idx"}, 32'(mc_idx), 32'(m_idx & 15));
    chk({tag, "_pos"}, 32'(position), p16(m_pos));
    chk({tag, "_mc"}, 32'(mc), 32'(m_pat[m_idx & 15]));
  endtask
  task automatic wr(input int a, input logic [7:0] d);
    pat_we = 1'b1;
    pat_addr = 4'(a);
    pat_wdata = d;
    cyc();
    pat_we = 1'b0;
    m_pat[a & 15] = d;
    if ((a & 15) == (m_idx & 15)) chk("wr_bypass_mc", 32'(mc), 32'(d));
  endtask
  task automatic sstep(input logic d, input int sz);
    step_dir = d;
    step_size = 4'(sz);
    step = 1'b1;
    cyc();
    step = 1'b0;
    m_idx = (m_idx + (d ? -1 : 1) * ((sz & 15) == 0 ? 1 : (sz & 15))) & 15;
    m_pos = m_pos + (d ? -1 : 1);
    chk("sstep_idx", 32'(mc_idx), 32'(m_idx));
    chk("sstep_busy", 32'(busy), 0);
    cyc();
    chk("sstep_mc", 32'(mc), 32'(m_pat[m_idx]));
    chk("sstep_pos", 32'(position), p16(m_pos));
  endtask
  // free-run for n cycles: steps taken by cycle k are k/(d+1)
  task automatic run_for(input int d, input int n, input logic dr, input int sz);
    int st, per, se;
    st = m_idx;
    per = d + 1;
    se = ((sz & 15) == 0 ? 1 : (sz & 15)) * (dr ? -1 : 1);
    step_delay = 16'(d);
    step_dir = dr;
    step_size = 4'(sz);
    run = 1'b1;
    cyc();
    chk("run_busy", 32'(busy), 1);
    for (int k = 1; k <= n; k++) begin
      step = 1'($urandom_range(0, 1));
      cyc();
      chk("run_idx", 32'(mc_idx), 32'((st + se * (k / per)) & 15));
    end
    step = 1'b0;
    run = 1'b0;
    cyc();
    chk("run_stop_busy", 32'(busy), 0);
    m_idx = (st + se * (n / per)) & 15;
    m_pos = m_pos + (dr ? -1 : 1) * (n / per);
    cyc();
    chk_state("run_end");
  endtask
  task automatic do_move(input int tgt, input int d);
    int n, done_k, ndone, sgn, se, k;
    step_delay = 16'(d);
    target = 16'(tgt);
    se = (step_size == 4'd0) ? 1 : int'(step_size);
    move_start = 1'b1;
    cyc();
    move_start = 1'b0;
    if (16'(tgt) == 16'(m_pos)) begin
      chk("move_eq_done", 32'(done), 1);
      chk("move_eq_busy", 32'(busy), 0);
      cyc();
      chk("move_eq_done_end", 32'(done), 0);
    end else begin
      chk("move_busy", 32'(busy), 1);
      sgn = (tgt < m_pos) ? -1 : 1;
      n = (tgt - m_pos) * sgn;
      done_k = -1;
      ndone = 0;
      for (k = 1; k <= 600; k++) begin
        cyc();
        if (done) begin
          ndone++;
          done_k = k;
        end
        if (!busy) break;
      end
      cyc();
      if (done) ndone++;
      chk("move_done_count", 32'(ndone), 1);
      chk("move_done_time", 32'(done_k), 32'(n * (d + 1)));
      chk("move_busy_end", 32'(busy), 0);
      m_pos = tgt;
      m_idx = (m_idx + sgn * se * n) & 15;
      chk_state("move_end");
    end
  endtask
  initial begin
    int nd, last, k, got, dly, iv;
    rst_n = 1'b0;
    pat_we = 0; pat_addr = 0; pat_wdata = 0; step_delay = 0; step_dir = 0; step_size = 1;
    run = 0; step = 0; move_start = 0; abort = 0; target = 0; pos_clr = 0;
    ramp_start = 0; ramp_dec = 0;
    for (int i = 0; i < 16; i++) m_pat[i] = 8'h0;
    repeat (2) cyc();
    chk("rst_mc", 32'(mc), 0);
    chk("rst_idx", 32'(mc_idx), 0);
    chk("rst_pos", 32'(position), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    cyc();
    // pattern[i] = i+1 then three unit steps forward
    for (int i = 0; i < 16; i++) wr(i, 8'(i + 1));
    cyc();
    for (int i = 0; i < 3; i++) sstep(1'b0, 1);
    chk("t1_idx3", 32'(mc_idx), 3);
    chk("t1_mc4", 32'(mc), 4);
    chk("t1_pos3", 32'(position), 3);
    wr(3, 8'hA5);
    cyc();
    chk_state("t1_wr");
    // free run, one step every 5 cycles
    run_for(4, 20, 1'b0, 1);
    // index wrap in both directions, size 0 acts as 1
    if (((15 - m_idx) & 15) != 0) sstep(1'b0, (15 - m_idx) & 15);
    sstep(1'b0, 3);
    chk("t3_wrap_up", 32'(mc_idx), 2);
    sstep(1'b1, 1);
    sstep(1'b1, 3);
    chk("t3_wrap_dn", 32'(mc_idx), 14);
    sstep(1'b0, 0);
    // move to -3, then a zero-length move
    step_size = 4'd1;
    pos_clr = 1'b1;
    cyc();
    pos_clr = 1'b0;
    m_pos = 0;
    chk("t4_clr", 32'(position), 0);
    do_move(-3, 1);
    chk("t4_pos", 32'(position), 32'h0000_FFFD);
    do_move(-3, 2);
    // abort mid-move: one step lands before abort is sampled
    step_delay = 16'd3;
    target = 16'(m_pos + 10);
    move_start = 1'b1;
    cyc();
    move_start = 1'b0;
    repeat (5) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) nd++;
      cyc();
    end
    chk("t5_abort_nodone", 32'(nd), 0);
    m_pos = m_pos + 1;
    m_idx = (m_idx + 1) & 15;
    chk_state("t5_abort");
    pos_clr = 1'b1;
    step = 1'b1;
    step_dir = 1'b0;
    step_size = 4'd1;
    cyc();
    pos_clr = 1'b0;
    step = 1'b0;
    m_pos = 0;
    m_idx = (m_idx + 1) & 15;
    cyc();
    chk_state("t5_clr_step");
    // asynchronous reset in the middle of a run
    step_delay = 16'd2;
    run = 1'b1;
    repeat (7) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_mc", 32'(mc), 0);
    chk("t5_arst_idx", 32'(mc_idx), 0);
    chk("t5_arst_pos", 32'(position), 0);
    chk("t5_arst_busy", 32'(busy), 0);
    chk("t5_arst_done", 32'(done), 0);
    run = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_pat[i] = 8'h0;
    m_idx = 0;
    m_pos = 0;
    cyc();
    // randomized mix of writes, single steps, runs and moves
    for (int i = 0; i < 16; i++) wr(i, 8'($urandom));
    cyc();
    chk_state("rnd_init");
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0: sstep(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        1: run_for(int'($urandom_range(0, 5)), int'($urandom_range(3, 25)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        2: begin
          step_size = 4'($urandom_range(0, 15));
          do_move(m_pos + int'($urandom_range(0, 24)) - 12, int'($urandom_range(0, 3)));
        end
        default: begin
          wr(m_idx, 8'($urandom));
          cyc();
          chk_state("rnd_wr");
        end
      endcase
    end
`ifdef RTMC_RAMP_EN
    // ramp: intervals shrink by ramp_dec down to step_delay+1
    ramp_start = 16'd20;
    ramp_dec = 16'd5;
    step_delay = 16'd5;
    step_dir = 1'b0;
    step_size = 4'd1;
    dly = 20;
    run = 1'b1;
    cyc();
    last = 0;
    got = 0;
    for (k = 1; k <= 200 && got < 5; k++) begin
      cyc();
      if (int'(mc_idx) != m_idx) begin
        iv = dly + 1;
        chk("ramp_interval", 32'(k - last), 32'(iv));
        dly = (dly - 5 > 5) ? dly - 5 : 5;
        last = k;
        got++;
        m_idx = (m_idx + 1) & 15;
        m_pos = m_pos + 1;
      end
    end
    chk("ramp_steps", 32'(got), 5);
    run = 1'b0;
    ramp_start = 16'd0;
    ramp_dec = 16'd0;
    cyc();
    cyc();
    chk_state("ramp_end");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
